// File: rtl/cordic_axi_lite_slave.sv
// cordic_axi_lite_slave: AXI4-Lite register front-end that launches the CORDIC core and captures its cos/sin results.
// Optional interrupt output and CTRL.IRQ_EN bit are built when CORDIC_AXI_IRQ_EN is defined.
module cordic_axi_lite_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic                              core_start_o,
    output logic [31:0]                       core_angle_o,
    input  logic                              core_done_i,
    input  logic [31:0]                       core_cos_i,
    input  logic [31:0]                       core_sin_i
`ifdef CORDIC_AXI_IRQ_EN
    , output logic                            irq_o
`endif
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state_q;
    logic        awready_q, bvalid_q, arready_q, rvalid_q, start_q, done_q;
    logic [31:0] rdata_q, angle_q, cos_q, sin_q, angle_d, rdata_d, ctrl_rd;
    logic        wr, rd, wr_ctrl;
    logic [1:0]  wsel;
    logic        unused_sigs;
`ifdef CORDIC_AXI_IRQ_EN
    logic        irq_en_q, irq_q;
    assign irq_o = irq_q;
`endif
    assign unused_sigs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign core_start_o    = start_q;
    assign core_angle_o    = angle_q;
    assign wr      = awready_q && s00_axi_awvalid && s00_axi_wvalid;
    assign rd      = arready_q && s00_axi_arvalid;
    assign wsel    = s00_axi_awaddr[3:2];
    assign wr_ctrl = wr && wsel == 2'd0 && s00_axi_wstrb[0];

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[1] = done_q;
        ctrl_rd[2] = state_q == BUSY;
`ifdef CORDIC_AXI_IRQ_EN
        ctrl_rd[8] = irq_en_q;
`endif
        angle_d = angle_q;
        for (int k = 0; k < 4; k++)
            if (s00_axi_wstrb[k]) angle_d[8*k +: 8] = s00_axi_wdata[8*k +: 8];
        rdata_d = s00_axi_araddr[3] ? (s00_axi_araddr[2] ? sin_q : cos_q)
                                    : (s00_axi_araddr[2] ? angle_q : ctrl_rd);
    end

    // awready/arready are suppressed while already high so a held valid is accepted once
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state_q   <= IDLE;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            angle_q   <= '0;
            cos_q     <= '0;
            sin_q     <= '0;
`ifdef CORDIC_AXI_IRQ_EN
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
`endif
        end else begin
            awready_q <= s00_axi_awvalid && s00_axi_wvalid && !bvalid_q && !awready_q;
            bvalid_q  <= wr ? 1'b1 : (s00_axi_bready ? 1'b0 : bvalid_q);
            arready_q <= s00_axi_arvalid && !rvalid_q && !arready_q;
            rvalid_q  <= rd ? 1'b1 : (s00_axi_rready ? 1'b0 : rvalid_q);
            if (rd) rdata_q <= rdata_d;
            if (wr && wsel == 2'd1) angle_q <= angle_d;
            start_q <= 1'b0;
`ifdef CORDIC_AXI_IRQ_EN
            if (wr && wsel == 2'd0 && s00_axi_wstrb[1]) irq_en_q <= s00_axi_wdata[8];
            irq_q <= done_q && irq_en_q;
`endif
            if (state_q == IDLE) begin
                if (wr_ctrl && s00_axi_wdata[0]) begin
                    state_q <= BUSY;
                    start_q <= 1'b1;
                    done_q  <= 1'b0;
                end else if (wr_ctrl && s00_axi_wdata[1]) begin
                    done_q  <= 1'b0;
                end
            end else if (core_done_i) begin
                state_q <= IDLE;
                cos_q   <= core_cos_i;
                sin_q   <= core_sin_i;
                done_q  <= 1'b1;
            end else if (wr_ctrl && s00_axi_wdata[1]) begin
                done_q  <= 1'b0;
            end
        end
    end
endmodule

// File: doc/cordic_axi_lite_slave.md
# cordic_axi_lite_slave

AXI4-Lite slave register front-end for the CORDIC IP: the responder side of the bus the master VIP drives in the block-design bench. It decodes four 32-bit registers at byte offsets 0x0–0xC, launches the CORDIC core with a one-cycle start pulse and captures its cos/sin results on completion. It sits between the AXI interconnect and the CORDIC datapath inside the IP's top wrapper.

## Interface
- C_S_AXI_DATA_WIDTH, 32, bus data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] are ignored.
- s00_axi_aclk  in  1  single clock; all logic is on the rising edge.
- s00_axi_aresetn  in  1  synchronous, active-low reset.
- s00_axi_awaddr / awprot / awvalid / awready  in/in/in/out  4/3/1/1  write address channel; awprot is ignored.
- s00_axi_wdata / wstrb / wvalid / wready  in/in/in/out  32/4/1/1  write data channel.
- s00_axi_bresp / bvalid / bready  out/out/in  2/1/1  write response channel; bresp is always 2'b00.
- s00_axi_araddr / arprot / arvalid / arready  in/in/in/out  4/3/1/1  read address channel.
- s00_axi_rdata / rresp / rvalid / rready  out/out/out/in  32/2/1/1  read data channel; rresp is always 2'b00.
- core_start_o  out  1  one-cycle launch pulse to the CORDIC core.
- core_angle_o  out  32  the ANGLE register value, driven continuously.
- core_done_i  in  1  one-cycle completion pulse from the core.
- core_cos_i / core_sin_i  in  32  core results; valid in the cycle core_done_i is high.
- irq_o  out  1  level interrupt; present only with CORDIC_AXI_IRQ_EN.

## Operation
- Register map:
  - 0x0 CTRL
    - bit0 START: write 1 requests a launch; reads as 0.
    - bit1 DONE: read-only and sticky; writing 1 clears it.
    - bit2 BUSY: read-only.
    - bit8 IRQ_EN: read/write when the macro is defined; otherwise reads 0.
  - 0x4 ANGLE: read/write.
  - 0x8 COS: read-only.
  - 0xC SIN: read-only.
- Byte writes: wstrb[k] enables byte k on read/write fields. Writes to read-only fields are dropped and still answered with OKAY.
- Core FSM (IDLE, BUSY):
  - IDLE→BUSY at the write-handshake edge when START=1 and the byte-0 strobe is set. core_start_o is high for the following cycle only. DONE clears at the same edge.
  - BUSY→IDLE on core_done_i. At that edge the core_cos_i and core_sin_i inputs are captured into COS and SIN, and DONE is set.
  - A START write while BUSY is ignored: no pulse is issued and ANGLE still updates.
  - core_done_i while IDLE is ignored.
- Simultaneous events:
  - A START write in the same cycle as core_done_i is ignored; the done is captured.
  - A DONE-clear write in the same cycle as core_done_i leaves DONE=1.
- Reset: every output is 0 (including awready, wready, arready, bvalid, rvalid, rdata, core_start_o, core_angle_o and irq_o), all registers are 0 and the FSM is in IDLE. Reset mid-transaction drops any outstanding B or R beat without completing it.

## Timing
- Write channel:
  - awready and wready are registered and rise together for exactly one cycle. They rise in cycle N+1 when awvalid, wvalid and !bvalid all hold in cycle N.
  - The register update happens at the N+1 edge.
  - bvalid rises in cycle N+2 and is held until bready; it clears the cycle after bvalid&&bready.
  - AW-only or W-only valid waits with no acceptance.
- Read channel:
  - arready pulses in cycle N+1 when arvalid && !rvalid in cycle N.
  - rdata is latched at the N+1 edge; rvalid rises in cycle N+2 and is held with stable rdata until rready.
- Throughput:
  - At most one outstanding write and one outstanding read.
  - The read and write channels operate independently in the same cycle.
- A read of CTRL returns the BUSY and DONE values as of the arready edge.
- irq_o is registered: it is high one cycle after the cycle in which DONE && IRQ_EN first holds.

## Configuration
- CORDIC_AXI_IRQ_EN defined:
  - CTRL bit8 IRQ_EN is implemented.
  - irq_o = registered DONE && IRQ_EN; clearing DONE deasserts irq_o on the next cycle.
- CORDIC_AXI_IRQ_EN undefined:
  - The irq_o port is absent.
  - CTRL bit8 reads 0 and writes to it are dropped.

## Test plan
- Reset held 10 cycles, then reads of 0x0–0xC → all return 0x00000000, OKAY; bvalid and rvalid stay 0 during reset.
- Write 0x12345678 to ANGLE, then read it back; then write 0xAABBCCDD with wstrb=4'b0101 → reads return 0x12345678, then 0x12BB56DD; core_angle_o matches each.
- Write CTRL=0x1 → core_start_o high for exactly one cycle and BUSY=1. The core model returns done with cos=0x0000B505 and sin=0x0000B505 → COS and SIN read 0x0000B505 and CTRL reads 0x2.
- START written while BUSY → no second core_start_o. START written in the same cycle as core_done_i → results captured, no start pulse, FSM ends in IDLE.
- AW valid 3 cycles before W valid, with bready held low 5 cycles → awready and wready pulse together once, and bvalid is held until bready. A concurrent read of SIN completes independently.
- With CORDIC_AXI_IRQ_EN: set IRQ_EN, then run a computation → irq_o rises one cycle after DONE. Write CTRL=0x102 → DONE=0 and irq_o falls the next cycle.
